// File: rtl/gray_pkg.sv
// Shared types and conversion helpers for the Gray-code conversion arbiter.
//   conv_mode_e  : per-request conversion direction.
//   rsp_state_e  : occupancy of the single registered response slot.
//   bin2gray()   : binary -> reflected Gray code.
//   gray2bin()   : reflected Gray code -> binary.
// The helpers work on VEC_W_MAX-bit vectors. A narrower word must be
// zero-extended before the call and truncated after it. Leading zeros map to
// leading zeros in both directions, so the low VEC_W bits of the result are
// exactly the VEC_W-bit conversion.
package gray_pkg;

  localparam int VEC_W_MAX = 32;

  typedef enum logic {
    BIN2GRAY = 1'b0,
    GRAY2BIN = 1'b1
  } conv_mode_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_e;

  function automatic logic [VEC_W_MAX-1:0] bin2gray(input logic [VEC_W_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit depends on the binary bit above it, so the loop runs
  // MSB-first.
  function automatic logic [VEC_W_MAX-1:0] gray2bin(input logic [VEC_W_MAX-1:0] gray);
    logic [VEC_W_MAX-1:0] bin;
    bin[VEC_W_MAX-1] = gray[VEC_W_MAX-1];
    for (int i = VEC_W_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_conv_unit.sv
// Combinational binary/Gray converter for one VEC_W-bit word.
// Ports:
//   word   : input word.
//   mode   : BIN2GRAY or GRAY2BIN.
//   result : converted word.
module gray_conv_unit
  import gray_pkg::*;
#(
  parameter int VEC_W = 4
) (
  input  logic [VEC_W-1:0] word,
  input  conv_mode_e       mode,
  output logic [VEC_W-1:0] result
);

  logic [VEC_W_MAX-1:0] word_ext;

  assign word_ext = VEC_W_MAX'(word);
  assign result   = VEC_W'((mode == GRAY2BIN) ? gray2bin(word_ext) : bin2gray(word_ext));

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one binary/Gray
// converter. The result goes into a single output register and is returned
// on one valid/ready response channel, tagged with the granted requester ID.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset.
//   req_valid_i  : per-requester request valid.
//   req_ready_o  : per-requester accept (one-hot or zero).
//   req_mode_i   : per-requester mode (0 = bin->Gray, 1 = Gray->bin).
//   req_data_i   : packed words, requester k at [k*VEC_W +: VEC_W].
//   rsp_valid_o  : result valid.
//   rsp_ready_i  : downstream accepts the result.
//   rsp_data_o   : converted word.
//   rsp_id_o     : index of the granted requester.
//   rsp_mode_o   : mode used for this result.
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int VEC_W   = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ-1:0]       req_mode_i,
  input  logic [NUM_REQ*VEC_W-1:0] req_data_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [VEC_W-1:0]         rsp_data_o,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic                     rsp_mode_o
);

  rsp_state_e       state, state_nxt;
  logic [ID_W-1:0]  ptr, ptr_nxt;
  logic [VEC_W-1:0] data_q, data_nxt;
  logic [ID_W-1:0]  id_q, id_nxt;
  conv_mode_e       mode_q, mode_nxt;

  logic [ID_W-1:0]  grant_id;
  logic             found;
  logic             accept;
  conv_mode_e       grant_mode;
  logic [VEC_W-1:0] conv_word;

  // Scan from the pointer upward, wrapping modulo NUM_REQ. The index is
  // reduced by one subtraction, so a pointer >= NUM_REQ is never produced.
  // NOTE: every variable written in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    int idx;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found    = 1'b1;
        grant_id = ID_W'(idx);
      end
    end
  end

  // The slot can take a new result when it is empty or is being drained in
  // this same cycle. That allows back-to-back results with no bubble.
  assign accept      = !reset && ((state == EMPTY) || rsp_ready_i) && found;
  assign req_ready_o = accept ? (NUM_REQ'(1) << grant_id) : '0;
  assign grant_mode  = conv_mode_e'(req_mode_i[grant_id]);

  gray_conv_unit #(.VEC_W(VEC_W)) u_conv (
    .word   (req_data_i[grant_id*VEC_W +: VEC_W]),
    .mode   (grant_mode),
    .result (conv_word)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    data_nxt  = data_q;
    id_nxt    = id_q;
    mode_nxt  = mode_q;
    if (accept) begin
      state_nxt = FULL;
      data_nxt  = conv_word;
      id_nxt    = grant_id;
      mode_nxt  = grant_mode;
      ptr_nxt   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end else if ((state == FULL) && rsp_ready_i) begin
      state_nxt = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      ptr    <= '0;
      data_q <= '0;
      id_q   <= '0;
      mode_q <= BIN2GRAY;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      data_q <= data_nxt;
      id_q   <= id_nxt;
      mode_q <= mode_nxt;
    end
  end

  assign rsp_valid_o = (state == FULL);
  assign rsp_data_o  = data_q;
  assign rsp_id_o    = id_q;
  assign rsp_mode_o  = logic'(mode_q);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter (NUM_REQ=4, VEC_W=4).
// Stimulus pushes the hand-computed response for every expected grant into a
// queue. A monitor on the falling edge compares each presented response
// against the head of the queue and pops it on handshake.
module tb_gray_conv_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid_i = '0;
  logic [3:0]  req_ready_o;
  logic [3:0]  req_mode_i = '0;
  logic [15:0] req_data_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [3:0]  rsp_data_o;
  logic [1:0]  rsp_id_o;
  logic        rsp_mode_o;

  typedef struct {
    logic [3:0] data;
    logic [1:0] id;
    logic       mode;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  gray_conv_arbiter #(.NUM_REQ(4), .VEC_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_mode_i  (req_mode_i),
    .req_data_i  (req_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_id_o    (rsp_id_o),
    .rsp_mode_o  (rsp_mode_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive just after the rising edge, check the
  // combinational ready at +4, queue the expected response if a grant is due.
  task automatic step(input logic [3:0] v, input logic [3:0] m, input logic [15:0] d,
                      input logic rdy, input logic [3:0] exp_rdy,
                      input logic [3:0] exp_data, input logic [1:0] exp_id,
                      input logic exp_mode);
    exp_t e;
    @(posedge clk);
    #1;
    req_valid_i = v;
    req_mode_i  = m;
    req_data_i  = d;
    rsp_ready_i = rdy;
    #3;
    check("req_ready", req_ready_o, exp_rdy);
    if (exp_rdy != 4'b0000) begin
      e.data = exp_data;
      e.id   = exp_id;
      e.mode = exp_mode;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    step(4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 4'h0, 2'd0, 1'b0);
  endtask

  // Monitor: every presented response must match the queue head. The head
  // leaves the queue only when the downstream accepts it.
  always @(negedge clk) begin
    if (!reset && rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d data %0h expected no response", rsp_id_o, rsp_data_o);
      end else begin
        check("rsp_data", rsp_data_o, exp_q[0].data);
        check("rsp_id",   rsp_id_o,   exp_q[0].id);
        check("rsp_mode", rsp_mode_o, exp_q[0].mode);
        if (rsp_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset phase: ready must stay low even with all requests valid.
    @(posedge clk);
    #1 req_valid_i = 4'b1111;
    #3 check("ready_in_reset", req_ready_o, 4'b0000);
    @(posedge clk);
    #1 reset = 1'b0; req_valid_i = 4'b0000;
    #3;
    check("reset_valid", rsp_valid_o, 1'b0);
    check("reset_data",  rsp_data_o,  4'h0);
    check("reset_id",    rsp_id_o,    2'd0);
    check("reset_mode",  rsp_mode_o,  1'b0);

    // Basic conversions and boundary words (pointer 0 -> 1 -> 3 -> 0 -> 1 -> 2).
    step(4'b0001, 4'b0000, 16'h0005, 1'b1, 4'b0001, 4'b0111, 2'd0, 1'b0);
    step(4'b0100, 4'b0100, 16'h0700, 1'b1, 4'b0100, 4'b0101, 2'd2, 1'b1);
    step(4'b1000, 4'b0000, 16'h8000, 1'b1, 4'b1000, 4'b1100, 2'd3, 1'b0);
    step(4'b0001, 4'b0001, 16'h000F, 1'b1, 4'b0001, 4'b1010, 2'd0, 1'b1);
    step(4'b0010, 4'b0000, 16'h00F0, 1'b1, 4'b0010, 4'b1000, 2'd1, 1'b0);
    idle();

    // Pointer is 2; grant requester 3 so the pointer wraps to 0.
    step(4'b1000, 4'b0000, 16'h2000, 1'b1, 4'b1000, 4'b0011, 2'd3, 1'b0);
    // All four valid: grants 0,1,2,3,0,1 with no idle cycles.
    step(4'b1111, 4'b0000, 16'h4321, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0);
    step(4'b1111, 4'b0000, 16'h4321, 1'b1, 4'b0010, 4'b0011, 2'd1, 1'b0);
    step(4'b1111, 4'b0000, 16'h4321, 1'b1, 4'b0100, 4'b0010, 2'd2, 1'b0);
    step(4'b1111, 4'b0000, 16'h4321, 1'b1, 4'b1000, 4'b0110, 2'd3, 1'b0);
    step(4'b1111, 4'b0000, 16'h4321, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0);
    step(4'b1111, 4'b0000, 16'h4321, 1'b1, 4'b0010, 4'b0011, 2'd1, 1'b0);
    idle();

    // Backpressure: pointer 2, requester 0 alone is granted (pointer -> 1).
    step(4'b0001, 4'b0001, 16'h0006, 1'b1, 4'b0001, 4'b0100, 2'd0, 1'b1);
    step(4'b0110, 4'b0000, 16'h0930, 1'b0, 4'b0000, 4'h0, 2'd0, 1'b0);
    step(4'b0110, 4'b0000, 16'h0930, 1'b0, 4'b0000, 4'h0, 2'd0, 1'b0);
    step(4'b0110, 4'b0000, 16'h0930, 1'b0, 4'b0000, 4'h0, 2'd0, 1'b0);
    step(4'b0110, 4'b0000, 16'h0930, 1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
    step(4'b0100, 4'b0000, 16'h0930, 1'b1, 4'b0100, 4'b1101, 2'd2, 1'b0);
    idle();

    // Wrap-around fairness: requester 3 (pointer -> 0), then 1001 grants 0.
    step(4'b1000, 4'b0000, 16'h5000, 1'b1, 4'b1000, 4'b0111, 2'd3, 1'b0);
    step(4'b1001, 4'b0000, 16'h5001, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0);
    // A single active requester is granted every cycle.
    step(4'b0010, 4'b0000, 16'h0040, 1'b1, 4'b0010, 4'b0110, 2'd1, 1'b0);
    step(4'b0010, 4'b0000, 16'h0040, 1'b1, 4'b0010, 4'b0110, 2'd1, 1'b0);
    idle();

    // Reset while FULL and stalled: the held result is discarded.
    step(4'b0100, 4'b0100, 16'h0F00, 1'b1, 4'b0100, 4'b1010, 2'd2, 1'b1);
    step(4'b0000, 4'b0000, 16'h0000, 1'b0, 4'b0000, 4'h0, 2'd0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1; req_valid_i = 4'b1111; req_data_i = 16'h4321; rsp_ready_i = 1'b0;
    exp_q.delete();
    #3 check("ready_in_reset2", req_ready_o, 4'b0000);
    @(posedge clk);
    #1 reset = 1'b0; req_valid_i = 4'b0000;
    #3;
    check("reset2_valid", rsp_valid_o, 1'b0);
    check("reset2_data",  rsp_data_o,  4'h0);
    check("reset2_id",    rsp_id_o,    2'd0);
    // The pointer was cleared, so the first grant goes to requester 0.
    step(4'b1111, 4'b0000, 16'h4321, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0);
    idle();

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
